// File: rtl/async_fifo_pkg.sv
// Shared types and width helpers for the async FIFO read-side packer.
package async_fifo_pkg;

   typedef enum logic [0:0] {
      ACC_EMPTY = 1'b0,
      ACC_PART  = 1'b1
   } acc_state_e;

   function automatic int keep_width(input int ratio);
      return ratio;
   endfunction

   function automatic int cnt_width(input int ratio);
      return $clog2(ratio) + 1;
   endfunction

endpackage

// File: rtl/async_fifo_rd_packer_chk.sv
// Simulation checks for the read packer: read data must only arrive for an issued read.
module async_fifo_rd_packer_chk (
   input logic clk,
   input logic rst_n,
   input logic valid,
   input logic inflight
);

   a_no_orphan_valid: assert property (@(posedge clk) disable iff (!rst_n) !(valid && !inflight));

endmodule

// File: rtl/rd_pack_timer.sv
// Idle counter that requests a partial flush after TIMEOUT idle cycles.
// Compiled only when RD_PACK_FLUSH_TIMEOUT_EN is defined.
`ifdef RD_PACK_FLUSH_TIMEOUT_EN
module rd_pack_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic fire
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] timer_r;

   assign fire = run && (timer_r == TW'(TIMEOUT - 1));

   // Count consecutive idle cycles; any non-idle cycle or a flush clears the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_r <= '0;
      end else if (run && !fire) begin
         timer_r <= timer_r + TW'(1);
      end else begin
         timer_r <= '0;
      end
   end

endmodule
`endif

// File: rtl/async_fifo_rd_packer.sv
// Read-side FIFO consumer that packs PACK_RATIO words into one valid/ready beat.
// Optional partial flush on idle timeout: define RD_PACK_FLUSH_TIMEOUT_EN.
module async_fifo_rd_packer
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                empty,
   input  logic                                valid,
   input  logic [DATA_WIDTH-1:0]               dout,
   output logic                                rd_en,
   output logic [DATA_WIDTH*PACK_RATIO-1:0]    m_data,
   output logic [keep_width(PACK_RATIO)-1:0]   m_keep,
   output logic                                m_valid,
   input  logic                                m_ready,
   output logic [cnt_width(PACK_RATIO)-1:0]    pack_cnt
);

   localparam int PACK_W = DATA_WIDTH * PACK_RATIO;
   localparam int KW     = keep_width(PACK_RATIO);
   localparam int CW     = cnt_width(PACK_RATIO);

   if (PACK_RATIO < 2 || TIMEOUT < 1) begin : g_bad_param
      $error("async_fifo_rd_packer: PACK_RATIO must be >= 2 and TIMEOUT >= 1");
   end

   logic [CW-1:0]     cnt_r;
   logic              inflight_r;
   logic [PACK_W-1:0] acc_r;
   logic [PACK_W-1:0] m_data_r;
   logic [KW-1:0]     m_keep_r;
   logic              m_valid_r;

   logic [CW-1:0]     sum_s;
   logic              rd_en_s;
   logic              arrive_s;
   logic              complete_s;
   logic              accept_s;
   logic              flush_s;
   logic [KW-1:0]     flush_keep_s;
   logic [PACK_W-1:0] word_placed_s;
   logic [PACK_W-1:0] acc_next_s;
   acc_state_e        acc_state_s;

   assign acc_state_s = (cnt_r == CW'(0)) ? ACC_EMPTY : ACC_PART;
   assign sum_s       = cnt_r + CW'(inflight_r);
   assign arrive_s    = valid && inflight_r;
   assign complete_s  = arrive_s && (cnt_r == CW'(PACK_RATIO - 1));
   assign accept_s    = m_valid_r && m_ready;

   // The completing read is only issued when the output slot is free, so a completed word never overflows.
   assign rd_en_s = !empty && !flush_s &&
                    ((sum_s < CW'(PACK_RATIO - 1)) ||
                     ((sum_s == CW'(PACK_RATIO - 1)) && !m_valid_r));

`ifdef RD_PACK_FLUSH_TIMEOUT_EN
   logic tmr_run_s;

   assign tmr_run_s = (acc_state_s == ACC_PART) && !inflight_r && empty && !m_valid_r;

   rd_pack_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (tmr_run_s),
      .fire  (flush_s)
   );

   // Lane mask for a partial flush: one bit per filled lane.
   always_comb begin
      flush_keep_s = '0;
      for (int i = 0; i < KW; i++) begin
         flush_keep_s[i] = (cnt_r > CW'(i));
      end
   end
`else
   assign flush_s      = 1'b0;
   assign flush_keep_s = '1;
`endif

   // Steer the arriving word into the lane selected by the fill count.
   always_comb begin
      word_placed_s = '0;
      for (int i = 0; i < PACK_RATIO; i++) begin
         word_placed_s[i*DATA_WIDTH +: DATA_WIDTH] = (cnt_r == CW'(i)) ? dout : '0;
      end
      if (acc_state_s == ACC_EMPTY) begin
         acc_next_s = word_placed_s;
      end else begin
         acc_next_s = acc_r | word_placed_s;
      end
   end

   // Accumulator, read tracking and output holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r      <= '0;
         inflight_r <= 1'b0;
         acc_r      <= '0;
         m_data_r   <= '0;
         m_keep_r   <= '0;
         m_valid_r  <= 1'b0;
      end else begin
         inflight_r <= rd_en_s;
         if (complete_s) begin
            m_data_r  <= acc_next_s;
            m_keep_r  <= '1;
            m_valid_r <= 1'b1;
            cnt_r     <= '0;
            acc_r     <= '0;
         end else if (flush_s) begin
            m_data_r  <= acc_r;
            m_keep_r  <= flush_keep_s;
            m_valid_r <= 1'b1;
            cnt_r     <= '0;
            acc_r     <= '0;
         end else begin
            if (arrive_s) begin
               acc_r <= acc_next_s;
               cnt_r <= cnt_r + CW'(1);
            end
            if (accept_s) begin
               m_valid_r <= 1'b0;
            end
         end
      end
   end

   async_fifo_rd_packer_chk u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (valid),
      .inflight (inflight_r)
   );

   assign rd_en    = rd_en_s;
   assign m_data   = m_data_r;
   assign m_keep   = m_keep_r;
   assign m_valid  = m_valid_r;
   assign pack_cnt = cnt_r;

endmodule

// File: tb/tb_async_fifo_rd_packer.sv
// Directed bench for async_fifo_rd_packer with a depth-8, latency-1 FIFO model.
module tb_async_fifo_rd_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        empty;
   logic        valid = 1'b0;
   logic [7:0]  dout = 8'h00;
   logic        rd_en;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [2:0]  pack_cnt;

   int total = 0;
   int bad = 0;
   int wr_ptr = 0;
   int rd_ptr = 0;
   int rd_pulses = 0;
   int overreads = 0;
   bit rnd_mode = 1'b0;
   logic [7:0]  mem [256];
   logic [31:0] beat_q [$];
   logic [3:0]  keep_q [$];

   always #5 clk = ~clk;

   assign empty = (wr_ptr == rd_ptr);

   async_fifo_rd_packer #(
      .DATA_WIDTH (8),
      .PACK_RATIO (4),
      .TIMEOUT    (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .empty    (empty),
      .valid    (valid),
      .dout     (dout),
      .rd_en    (rd_en),
      .m_data   (m_data),
      .m_keep   (m_keep),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .pack_cnt (pack_cnt)
   );

   // FIFO read port model: one-cycle read latency, reset together with the packer.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= wr_ptr;
         valid  <= 1'b0;
         dout   <= 8'h00;
      end else begin
         valid <= 1'b0;
         if (rd_en) begin
            rd_pulses <= rd_pulses + 1;
            if (empty) begin
               overreads <= overreads + 1;
            end else begin
               dout   <= mem[rd_ptr[7:0]];
               rd_ptr <= rd_ptr + 1;
               valid  <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: note the handshake before the edge, look at the result after it.
   task automatic step();
      logic        pv;
      logic        pr;
      logic [31:0] pd;
      logic [3:0]  pk;
      if (rnd_mode) m_ready = 1'($urandom_range(0, 1));
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      pk = m_keep;
      @(posedge clk);
      #1;
      if (pv && pr) begin
         beat_q.push_back(pd);
         keep_q.push_back(pk);
      end
      if (pv && !pr && rst_n) chk("hold_stable", {27'd0, m_valid, m_keep, m_data}, {27'd0, 1'b1, pk, pd});
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] w);
      int k = 0;
      while ((wr_ptr - rd_ptr) >= 8 && k < 500) begin
         step();
         k++;
      end
      if (k >= 500) begin
         total++;
         bad++;
         $error("FAIL push_room: observed fill=%0d required below 8", wr_ptr - rd_ptr);
      end
      mem[wr_ptr[7:0]] = w;
      wr_ptr++;
   endtask

   task automatic wait_beats(input int n, input int budget);
      int k = 0;
      while (beat_q.size() < n && k < budget) begin
         step();
         k++;
      end
      if (beat_q.size() < n) begin
         total++;
         bad++;
         $error("FAIL wait_beats: observed beats=%0d required=%0d", beat_q.size(), n);
      end
   endtask

   task automatic check_beat(input string tag, input logic [31:0] d, input logic [3:0] k);
      if (beat_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s: observed no beat expected=%0h", tag, d);
      end else begin
         chk(tag, 64'(beat_q.pop_front()), 64'(d));
         chk({tag, "_keep"}, 64'(keep_q.pop_front()), 64'(k));
      end
   endtask

   initial begin
      int base;
      int seen;
      logic [7:0]  words [64];
      logic [31:0] exp_w;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_m_keep", 64'(m_keep), 64'd0);
      chk("rst_pack_cnt", 64'(pack_cnt), 64'd0);
      rst_n = 1'b1;

      // 1: one full beat with the consumer ready
      m_ready = 1'b1;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      wait_beats(1, 50);
      repeat (3) step();
      chk("t1_count", 64'(beat_q.size()), 64'd1);
      check_beat("t1_beat", 32'h44332211, 4'hF);
      chk("t1_pack_cnt", 64'(pack_cnt), 64'd0);
      chk("t1_m_valid", 64'(m_valid), 64'd0);

      // 2: back-pressure, reads stop with three lanes filled
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      repeat (30) step();
      chk("t2_m_valid", 64'(m_valid), 64'd1);
      chk("t2_m_data", 64'(m_data), 64'h04030201);
      chk("t2_m_keep", 64'(m_keep), 64'hF);
      chk("t2_pack_cnt", 64'(pack_cnt), 64'd3);
      chk("t2_rd_en", 64'(rd_en), 64'd0);
      chk("t2_fifo_left", 64'(wr_ptr - rd_ptr), 64'd1);
      chk("t2_no_beat", 64'(beat_q.size()), 64'd0);
      m_ready = 1'b1;
      wait_beats(2, 50);
      repeat (3) step();
      chk("t2_count", 64'(beat_q.size()), 64'd2);
      check_beat("t2_beat0", 32'h04030201, 4'hF);
      check_beat("t2_beat1", 32'h08070605, 4'hF);
      chk("t2_pack_cnt_end", 64'(pack_cnt), 64'd0);

      // 3: long empty period
      base = rd_pulses;
      seen = 0;
      repeat (1000) begin
         step();
         if (m_valid || rd_en) seen++;
      end
      chk("t3_rd_pulses", 64'(rd_pulses - base), 64'd0);
      chk("t3_activity", 64'(seen), 64'd0);

      // 4: reset in the middle of a fill
      push(8'hAA); push(8'hBB);
      repeat (6) step();
      chk("t4_pack_cnt_pre", 64'(pack_cnt), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("t4_m_valid", 64'(m_valid), 64'd0);
      chk("t4_m_data", 64'(m_data), 64'd0);
      chk("t4_m_keep", 64'(m_keep), 64'd0);
      chk("t4_pack_cnt", 64'(pack_cnt), 64'd0);
      chk("t4_rd_en", 64'(rd_en), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      wait_beats(1, 50);
      repeat (2) step();
      chk("t4_count", 64'(beat_q.size()), 64'd1);
      check_beat("t4_beat", 32'h04030201, 4'hF);

      // 5: partial word followed by idle
      push(8'hAA); push(8'hBB);
      repeat (40) step();
`ifdef RD_PACK_FLUSH_TIMEOUT_EN
      chk("t5_count", 64'(beat_q.size()), 64'd1);
      check_beat("t5_flush", 32'h0000BBAA, 4'b0011);
      chk("t5_pack_cnt", 64'(pack_cnt), 64'd0);
`else
      chk("t5_m_valid", 64'(m_valid), 64'd0);
      chk("t5_pack_cnt", 64'(pack_cnt), 64'd2);
      chk("t5_count", 64'(beat_q.size()), 64'd0);
`endif
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;

      // 6: random back-pressure stream
      rnd_mode = 1'b1;
      for (int i = 0; i < 64; i++) begin
         words[i] = 8'(i * 7 + 3);
         push(words[i]);
      end
      wait_beats(16, 3000);
      rnd_mode = 1'b0;
      m_ready = 1'b1;
      repeat (4) step();
      chk("t6_count", 64'(beat_q.size()), 64'd16);
      for (int j = 0; j < 16; j++) begin
         exp_w = {words[4*j+3], words[4*j+2], words[4*j+1], words[4*j]};
         check_beat($sformatf("t6_beat%0d", j), exp_w, 4'hF);
      end

      chk("overreads", 64'(overreads), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
